// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button debounce/edge detect and h/m/s edit FSM for the clock.
// Optional auto-repeat of held inc/dec when TIME_SET_AUTO_REPEAT_EN is defined.
module time_set_ctrl #(
   parameter int unsigned DEB_CYCLES = 16,
   parameter int unsigned RPT_DELAY  = 25000000,
   parameter int unsigned RPT_PERIOD = 5000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       btn_dec,
   input  logic [6:0] cur_h,
   input  logic [6:0] cur_m,
   input  logic [6:0] cur_s,
   output logic [6:0] set_h,
   output logic [6:0] set_m,
   output logic [6:0] set_s,
   output logic       load,
   output logic       editing,
   output logic [1:0] field_sel
);

   localparam int unsigned DW = $clog2(DEB_CYCLES);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

   localparam int B_MODE = 0;
   localparam int B_INC  = 1;
   localparam int B_DEC  = 2;

   localparam logic [6:0] H_TOP  = 7'd23;
   localparam logic [6:0] MS_TOP = 7'd59;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SET_H,
      S_SET_M,
      S_SET_S,
      S_COMMIT
   } state_t;

   logic [2:0]    btn_raw;
   logic [2:0]    sync1_q;
   logic [2:0]    sync2_q;
   logic [2:0]    deb_q;
   logic [2:0]    deb_prev_q;
   logic [DW-1:0] cnt_q [3];
   logic [2:0]    press;

   state_t     state_q;
   logic [6:0] set_h_q;
   logic [6:0] set_m_q;
   logic [6:0] set_s_q;
   logic       load_q;
   logic       editing_q;
   logic [1:0] field_sel_q;

   logic       mode_p;
   logic       rpt_inc;
   logic       rpt_dec;
   logic       step_inc;
   logic       step_dec;
   logic [6:0] set_h_d;
   logic [6:0] set_m_d;
   logic [6:0] set_s_d;
   logic [6:0] cap_h;
   logic [6:0] cap_m;
   logic [6:0] cap_s;

   assign btn_raw = {btn_dec, btn_inc, btn_mode};

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q    <= btn_raw;
         sync2_q    <= sync1_q;
         deb_prev_q <= deb_q;
         for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == DEB_LAST) begin
               deb_q[i] <= ~deb_q[i];
               cnt_q[i] <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign press  = deb_q & ~deb_prev_q;
   assign mode_p = press[B_MODE];

`ifdef TIME_SET_AUTO_REPEAT_EN
   localparam int unsigned RMAX =
      (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
   localparam int unsigned RW = $clog2(RMAX + 1);
   localparam logic [RW-1:0] DLY_LAST = RW'(RPT_DELAY - 1);
   localparam logic [RW-1:0] PER_LAST = RW'(RPT_PERIOD - 1);

   logic          in_set;
   logic          hold;
   logic          rpt_fire;
   logic [RW-1:0] rpt_cnt_q;
   logic          rpt_armed_q;

   assign in_set = (state_q == S_SET_H) ||
                   (state_q == S_SET_M) ||
                   (state_q == S_SET_S);

   // Mode press means the state is about to change, so the hold restarts.
   assign hold = in_set && !mode_p &&
                 (deb_q[B_INC] ^ deb_q[B_DEC]);

   assign rpt_fire = hold &&
      (rpt_cnt_q == (rpt_armed_q ? PER_LAST : DLY_LAST));

   always_ff @(posedge clk) begin
      if (rst || !hold) begin
         rpt_cnt_q   <= '0;
         rpt_armed_q <= 1'b0;
      end else if (rpt_fire) begin
         rpt_cnt_q   <= '0;
         rpt_armed_q <= 1'b1;
      end else begin
         rpt_cnt_q   <= rpt_cnt_q + 1'b1;
      end
   end

   assign rpt_inc = rpt_fire & deb_q[B_INC];
   assign rpt_dec = rpt_fire & deb_q[B_DEC];
`else
   logic unused_rpt;

   assign unused_rpt = ^(RPT_DELAY ^ RPT_PERIOD);
   assign rpt_inc    = 1'b0;
   assign rpt_dec    = 1'b0;
`endif

   assign step_inc = press[B_INC] | rpt_inc;
   assign step_dec = press[B_DEC] | rpt_dec;

   function automatic logic [6:0] step_fn(
      input logic [6:0] v,
      input logic [6:0] top,
      input logic       up,
      input logic       dn
   );
      logic [6:0] r;
      r = v;
      if (up && !dn) begin
         r = (v >= top) ? 7'd0 : v + 7'd1;
      end else if (dn && !up) begin
         r = ((v == 7'd0) || (v > top)) ? top : v - 7'd1;
      end
      return r;
   endfunction

   always_comb begin
      set_h_d = step_fn(set_h_q, H_TOP, step_inc, step_dec);
      set_m_d = step_fn(set_m_q, MS_TOP, step_inc, step_dec);
      set_s_d = step_fn(set_s_q, MS_TOP, step_inc, step_dec);
   end

   assign cap_h = (cur_h > H_TOP)  ? 7'd0 : cur_h;
   assign cap_m = (cur_m > MS_TOP) ? 7'd0 : cur_m;
   assign cap_s = (cur_s > MS_TOP) ? 7'd0 : cur_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         set_h_q     <= '0;
         set_m_q     <= '0;
         set_s_q     <= '0;
         load_q      <= 1'b0;
         editing_q   <= 1'b0;
         field_sel_q <= 2'd0;
      end else begin
         load_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (mode_p) begin
                  state_q     <= S_SET_H;
                  set_h_q     <= cap_h;
                  set_m_q     <= cap_m;
                  set_s_q     <= cap_s;
                  editing_q   <= 1'b1;
                  field_sel_q <= 2'd1;
               end
            end
            S_SET_H: begin
               if (mode_p) begin
                  state_q     <= S_SET_M;
                  field_sel_q <= 2'd2;
               end else begin
                  set_h_q <= set_h_d;
               end
            end
            S_SET_M: begin
               if (mode_p) begin
                  state_q     <= S_SET_S;
                  field_sel_q <= 2'd3;
               end else begin
                  set_m_q <= set_m_d;
               end
            end
            S_SET_S: begin
               if (mode_p) begin
                  state_q     <= S_COMMIT;
                  field_sel_q <= 2'd0;
                  load_q      <= 1'b1;
               end else begin
                  set_s_q <= set_s_d;
               end
            end
            S_COMMIT: begin
               state_q     <= S_IDLE;
               editing_q   <= 1'b0;
               field_sel_q <= 2'd0;
            end
            default: begin
               state_q     <= S_IDLE;
               editing_q   <= 1'b0;
               field_sel_q <= 2'd0;
            end
         endcase
      end
   end

   assign set_h     = set_h_q;
   assign set_m     = set_m_q;
   assign set_s     = set_s_q;
   assign load      = load_q;
   assign editing   = editing_q;
   assign field_sel = field_sel_q;

endmodule
